// File: rtl/pipe_if_stage_if.sv
// Instruction-memory read channel between the fetch stage (master) and imem (slave).
interface pipe_if_stage_if;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_rd,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_rd,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC, imem read handshake, IF/ID register, load-use hold
// and delayed-slot redirect with a pending target when no fetch completes.
module pipe_if_stage (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wpcir,
  input  logic [1:0]               pcsource,
  input  logic [31:0]              bpc,
  input  logic [31:0]              rpc,
  input  logic [31:0]              jpc,
  pipe_if_stage_if.master          imem,
  output logic [31:0]              pc,
  output logic [31:0]              dinst,
  output logic [31:0]              dpc4,
  output logic                     dvalid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   dinst_q;
  logic [XLEN-1:0]   dpc4_q;
  logic              dvalid_q;
  logic [XLEN-1:0]   hold_q;
  logic              pend_q;
  logic [XLEN-1:0]   redir_q;
  logic              rd_q;

  logic [XLEN-1:0]   pc4_c;
  logic [XLEN-1:0]   target_c;
  logic              redir_live_c;
  logic [XLEN-1:0]   next_pc_c;
  logic              fetch_done_c;
  logic [XLEN-1:0]   fetch_word_c;

  // Next-PC selection: a stored redirect outranks the live one, pcsource only counts for a real instruction.
  always_comb begin
    pc4_c        = pc_q + XLEN'(4);
    target_c     = pc4_c;
    unique case (pcsource)
      2'b01:   target_c = bpc;
      2'b10:   target_c = rpc;
      2'b11:   target_c = jpc;
      default: target_c = pc4_c;
    endcase
    redir_live_c = dvalid_q && (pcsource != 2'b00);
    if (pend_q) begin
      next_pc_c = redir_q;
    end else if (redir_live_c) begin
      next_pc_c = target_c;
    end else begin
      next_pc_c = pc4_c;
    end
    fetch_done_c = wpcir && (((state_q == ST_REQ) && imem.imem_ack) || (state_q == ST_HOLD));
    fetch_word_c = (state_q == ST_HOLD) ? hold_q : imem.imem_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      dinst_q  <= '0;
      dpc4_q   <= '0;
      dvalid_q <= 1'b0;
      hold_q   <= '0;
      pend_q   <= 1'b0;
      redir_q  <= '0;
      rd_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_q <= ST_REQ;
          rd_q    <= 1'b1;
        end
        ST_REQ: begin
          if (imem.imem_ack && !wpcir) begin
            hold_q  <= imem.imem_rdata;
            state_q <= ST_HOLD;
            rd_q    <= 1'b0;
          end else if (!imem.imem_ack && wpcir) begin
            dinst_q  <= '0;
            dvalid_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (wpcir) begin
            state_q <= ST_REQ;
            rd_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rd_q    <= 1'b0;
        end
      endcase

      if (fetch_done_c) begin
        dinst_q  <= fetch_word_c;
        dpc4_q   <= pc4_c;
        dvalid_q <= 1'b1;
        pc_q     <= next_pc_c;
      end

      // A redirect leaving ID without a completing fetch is parked for the next completion.
      if (fetch_done_c) begin
        pend_q <= 1'b0;
      end else if (redir_live_c && wpcir) begin
        pend_q  <= 1'b1;
        redir_q <= target_c;
      end
    end
  end

  assign imem.imem_rd   = rd_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign dinst          = dinst_q;
  assign dpc4           = dpc4_q;
  assign dvalid         = dvalid_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed bench for pipe_if_stage: sequential fetch, delay slot, load-use hold,
// pending redirect, PC wrap and reset mid-read.
module tb_pipe_if_stage;

  logic        clock;
  logic        reset;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] rpc;
  logic [31:0] jpc;
  logic [31:0] pc;
  logic [31:0] dinst;
  logic [31:0] dpc4;
  logic        dvalid;

  int checks;
  int failures;

  pipe_if_stage_if imem ();

  pipe_if_stage dut (
    .clock    (clock),
    .reset    (reset),
    .wpcir    (wpcir),
    .pcsource (pcsource),
    .bpc      (bpc),
    .rpc      (rpc),
    .jpc      (jpc),
    .imem     (imem.master),
    .pc       (pc),
    .dinst    (dinst),
    .dpc4     (dpc4),
    .dvalid   (dvalid)
  );

  // Memory returns its address tagged in the top nibble.
  always_comb imem.imem_rdata = imem.imem_addr | 32'hA000_0000;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [31:0] e_pc, input logic e_rd,
                           input logic [31:0] e_dinst, input logic [31:0] e_dpc4,
                           input logic e_dvalid);
    check({tag, ".imem_addr"}, imem.imem_addr, e_pc);
    check({tag, ".pc"},        pc,             e_pc);
    check({tag, ".imem_rd"},   32'(imem.imem_rd), 32'(e_rd));
    check({tag, ".dinst"},     dinst,          e_dinst);
    check({tag, ".dpc4"},      dpc4,           e_dpc4);
    check({tag, ".dvalid"},    32'(dvalid),    32'(e_dvalid));
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    wpcir    = 1'b1;
    pcsource = 2'b00;
    bpc      = 32'h0;
    rpc      = 32'h0;
    jpc      = 32'h0;
    imem.imem_ack = 1'b0;

    // Reset state, then sequential fetch with ack every cycle
    cyc(); expect_st("rst", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    cyc(); expect_st("idle2req", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    imem.imem_ack = 1'b1;
    cyc(); expect_st("seq0", 32'h4,  1'b1, 32'hA000_0000, 32'h4,  1'b1);
    cyc(); expect_st("seq1", 32'h8,  1'b1, 32'hA000_0004, 32'h8,  1'b1);
    cyc(); expect_st("seq2", 32'hC,  1'b1, 32'hA000_0008, 32'hC,  1'b1);
    cyc(); expect_st("seq3", 32'h10, 1'b1, 32'hA000_000C, 32'h10, 1'b1);

    // beq in ID while delay slot at 0x10 acks
    pcsource = 2'b01; bpc = 32'h40;
    cyc(); expect_st("beq", 32'h40, 1'b1, 32'hA000_0010, 32'h14, 1'b1);
    pcsource = 2'b00;
    cyc(); expect_st("beq_tgt", 32'h44, 1'b1, 32'hA000_0040, 32'h44, 1'b1);

    // Load-use stall with ack at 0x08
    reset = 1'b1;
    cyc(); expect_st("rst2", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0; imem.imem_ack = 1'b0;
    cyc(); expect_st("idle2req2", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    imem.imem_ack = 1'b1;
    cyc(); expect_st("b_seq0", 32'h4, 1'b1, 32'hA000_0000, 32'h4, 1'b1);
    cyc(); expect_st("b_seq1", 32'h8, 1'b1, 32'hA000_0004, 32'h8, 1'b1);
    wpcir = 1'b0;
    cyc(); expect_st("hold0", 32'h8, 1'b0, 32'hA000_0004, 32'h8, 1'b1);
    cyc(); expect_st("hold1", 32'h8, 1'b0, 32'hA000_0004, 32'h8, 1'b1);
    cyc(); expect_st("hold2", 32'h8, 1'b0, 32'hA000_0004, 32'h8, 1'b1);
    wpcir = 1'b1;
    cyc(); expect_st("unhold", 32'hC, 1'b1, 32'hA000_0008, 32'hC, 1'b1);

    // jr in ID with fetch ack delayed 4 cycles: bubbles, then stored target
    pcsource = 2'b10; rpc = 32'h200; imem.imem_ack = 1'b0;
    cyc(); expect_st("jr_bub0", 32'hC, 1'b1, 32'h0, 32'hC, 1'b0);
    rpc = 32'h300;
    cyc(); expect_st("jr_bub1", 32'hC, 1'b1, 32'h0, 32'hC, 1'b0);
    cyc(); expect_st("jr_bub2", 32'hC, 1'b1, 32'h0, 32'hC, 1'b0);
    cyc(); expect_st("jr_bub3", 32'hC, 1'b1, 32'h0, 32'hC, 1'b0);
    imem.imem_ack = 1'b1;
    cyc(); expect_st("jr_ack", 32'h200, 1'b1, 32'hA000_000C, 32'h10, 1'b1);
    pcsource = 2'b00;
    cyc(); expect_st("jr_clr", 32'h204, 1'b1, 32'hA000_0200, 32'h204, 1'b1);

    // Jump to the top of the address space, then wrap
    pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
    cyc(); expect_st("j_top", 32'hFFFF_FFFC, 1'b1, 32'hA000_0204, 32'h208, 1'b1);
    pcsource = 2'b00;
    cyc(); expect_st("wrap", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Run to 0x20, then reset in REQ with a same-cycle ack
    for (int i = 1; i <= 8; i++) begin
      cyc();
      expect_st($sformatf("run%0d", i), 32'(4 * i), 1'b1,
                32'hA000_0000 | 32'(4 * (i - 1)), 32'(4 * i), 1'b1);
    end
    reset = 1'b1;
    cyc(); expect_st("rst_mid", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    cyc(); expect_st("rst_idle_ack", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    cyc(); expect_st("rst_refetch", 32'h4, 1'b1, 32'hA000_0000, 32'h4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_if_stage.md
PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; ports SHALL be as listed in REQ-002 to REQ-013.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 wpcir  in  1  ID-stage advance enable; 0 = load-use stall, IF/ID and PC hold.
REQ-005 pcsource  in  2  next-PC select for the instruction in ID: 00 pc+4, 01 branch (bpc), 10 jr (rpc), 11 j/jal (jpc).
REQ-006 bpc, rpc, jpc  in  32 each  branch, register and jump targets from ID.
REQ-007 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-008 imem_ack  in  1  one-cycle completion strobe for the outstanding read.
REQ-009 imem_rd  out  1  read request; held high until imem_ack.
REQ-010 imem_addr  out  32  read address, equal to pc.
REQ-011 pc  out  32  address of the instruction being fetched.
REQ-012 dinst, dpc4  out  32 each  IF/ID register: instruction word and its address+4.
REQ-013 dvalid  out  1  1 = dinst is a real instruction; 0 = bubble (dinst=0, sll $0 nop).

Function
REQ-014 FSM states SHALL be IDLE (imem_rd=0), REQ (imem_rd=1, awaiting ack), HOLD (word captured, awaiting wpcir).
REQ-015 IDLE SHALL move to REQ unconditionally on the next edge.
REQ-016 REQ, imem_ack=1, wpcir=1: dinst<=imem_rdata, dpc4<=pc+4, dvalid<=1, pc<=next_pc, stay REQ (new read issued next cycle, 1 instr/cycle sustained).
REQ-017 REQ, imem_ack=1, wpcir=0: word SHALL be latched in an internal hold register, IF/ID and pc unchanged, go to HOLD.
REQ-018 REQ, imem_ack=0, wpcir=1: IF/ID SHALL load a bubble (dinst=0, dvalid=0, dpc4 unchanged); pc unchanged.
REQ-019 REQ, imem_ack=0, wpcir=0: IF/ID and pc unchanged.
REQ-020 HOLD, wpcir=1: IF/ID loads the held word (dvalid=1, dpc4=pc+4), pc<=next_pc, go to REQ; HOLD, wpcir=0: all hold; imem_rd=0 in HOLD.
REQ-021 imem_addr SHALL stay constant from imem_rd rising until the ack cycle inclusive.
REQ-022 next_pc priority: pending redirect if set; else if dvalid=1 and pcsource!=00, the pcsource-selected target; else pc+4 (all 32-bit, wrap-around at 2^32 without flag).
REQ-023 Branch semantics SHALL be delayed-slot: the word fetched while a branch/jump is in ID executes; no flush exists.
REQ-024 Pending redirect: when dvalid=1, pcsource!=00, wpcir=1 and no fetch completes that cycle, the selected target SHALL be stored with a pending flag; the flag SHALL clear on the next fetch completion, which uses the stored target.
REQ-025 With dvalid=0, pcsource SHALL be ignored.
REQ-026 imem_ack in IDLE or HOLD SHALL be ignored.
REQ-027 Simultaneous ack and redirect in the same cycle SHALL use the live target directly (no pending set).

Reset
REQ-028 On reset edge: state=IDLE, pc=0, imem_rd=0, dinst=0, dpc4=0, dvalid=0, hold register=0, pending flag=0.
REQ-029 Reset mid-read (REQ or HOLD) SHALL abandon the read; the held word and any ack in the following cycle are discarded.

Verification
REQ-030 Reset, then ack every REQ cycle with rdata=addr|0xA000_0000, wpcir=1 -> imem_addr 0,4,8,...; dinst/dpc4 follow 1 cycle after ack; dvalid=1 continuous.
REQ-031 ID holds beq (dvalid=1, pcsource=01, bpc=0x40) while fetch at 0x10 acks -> delay slot 0x10 enters ID, next imem_addr=0x40.
REQ-032 ack at 0x08 with wpcir=0 for 3 cycles -> HOLD, imem_rd=0, IF/ID frozen; wpcir=1 -> word of 0x08 loaded, imem_addr=0x0C.
REQ-033 ID holds jr (pcsource=10, rpc=0x200), fetch ack delayed 4 cycles -> bubbles (dvalid=0, dinst=0) inserted, pending set, after ack imem_addr=0x200, pending cleared.
REQ-034 reset asserted while in REQ at pc=0x20 with ack same cycle -> all outputs at REQ-028 values, imem_addr=0 in the REQ cycle after IDLE.
REQ-035 pc=0xFFFF_FFFC, ack, pcsource=00 -> next imem_addr=0x0000_0000, dpc4=0x0000_0000.
